// File: rtl/bch_pkg.sv
// Shared definitions for the BCH syndrome scheduler: default widths, FSM
// state encodings and a width helper.
package bch_pkg;

  localparam int C_INDWIDTH_DEF = 31;
  localparam int C_ERR_NUM_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  // Ceiling log2, floored at 1 so that index and counter fields never collapse to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bch_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts one past the
// pointer and wraps, producing a one-hot grant, its index and an any-grant flag.
module bch_rr_arbiter
  import bch_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  localparam int C_PTR_W  = clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [C_PTR_W-1:0]   ptr,
  output logic [C_NUM_REQ-1:0] grant,
  output logic [C_PTR_W-1:0]   grant_idx,
  output logic                 grant_any
);

  always_comb begin
    int r;
    r         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      r = (int'(ptr) + k) % C_NUM_REQ;
      if (!grant_any && req[r]) begin
        grant_any = 1'b1;
        grant[r]  = 1'b1;
        grant_idx = C_PTR_W'(r);
      end
    end
  end

endmodule

// File: rtl/bch_syndrome_sched.sv
// Round-robin scheduler sharing one registered BCH syndrome unit between
// several codeword requesters; one codeword in flight at a time.
module bch_syndrome_sched
  import bch_pkg::*;
#(
  parameter int C_INDWIDTH = C_INDWIDTH_DEF,
  parameter int C_ERR_NUM  = C_ERR_NUM_DEF,
  parameter int C_NUM_REQ  = 4,
  parameter int C_SYN_LAT  = 1,
  localparam int C_ID_W    = clog2(C_NUM_REQ),
  localparam int C_CNT_W   = clog2(C_SYN_LAT + 1),
  localparam int C_SYN_W   = C_INDWIDTH * C_ERR_NUM
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic [C_NUM_REQ-1:0]            I_req_valid,
  input  logic [C_NUM_REQ*C_INDWIDTH-1:0] I_req_codeword,
  output logic [C_NUM_REQ-1:0]            O_req_ready,
  output logic [C_INDWIDTH-1:0]           O_syn_codeword,
  input  logic [C_SYN_W-1:0]              I_syn_syndromes,
  output logic                            O_res_valid,
  input  logic                            I_res_ready,
  output logic [C_ID_W-1:0]               O_res_id,
  output logic [C_SYN_W-1:0]              O_res_syndromes,
  output logic                            O_res_err
);

  sched_state_e          state_q, state_d;
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic [C_ID_W-1:0]     ptr_q, ptr_d;
  logic [C_ID_W-1:0]     id_q, id_d;
  logic [C_INDWIDTH-1:0] cw_q, cw_d;
  logic                  res_valid_q, res_valid_d;
  logic [C_ID_W-1:0]     res_id_q, res_id_d;
  logic [C_SYN_W-1:0]    res_syn_q, res_syn_d;
  logic                  res_err_q, res_err_d;

  logic [C_NUM_REQ-1:0]  grant;
  logic [C_ID_W-1:0]     grant_idx;
  logic                  grant_any;

  bch_rr_arbiter #(
    .C_NUM_REQ (C_NUM_REQ)
  ) u_arb (
    .req       (I_req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cw_d        = cw_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_syn_d   = res_syn_q;
    res_err_d   = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          cw_d    = I_req_codeword[grant_idx*C_INDWIDTH +: C_INDWIDTH];
          id_d    = grant_idx;
          ptr_d   = grant_idx;
          cnt_d   = C_CNT_W'(C_SYN_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          res_syn_d   = I_syn_syndromes;
          res_err_d   = |I_syn_syndromes;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (I_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= C_ID_W'(C_NUM_REQ - 1);
      id_q        <= '0;
      cw_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_syn_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cw_q        <= cw_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_syn_q   <= res_syn_d;
      res_err_q   <= res_err_d;
    end
  end

  // The grant is combinational, so it is gated by reset to keep every output low while reset is held.
  assign O_req_ready     = (state_q == ST_IDLE && I_rst_n) ? grant : '0;
  assign O_syn_codeword  = cw_q;
  assign O_res_valid     = res_valid_q;
  assign O_res_id        = res_id_q;
  assign O_res_syndromes = res_syn_q;
  assign O_res_err       = res_err_q;

endmodule

// File: tb/tb_bch_syndrome_sched.sv
// Self-checking bench for bch_syndrome_sched: a GF(2^31) syndrome-unit model
// feeds the DUT, and a transaction-level scoreboard predicts grants and results.
module tb_bch_syndrome_sched;
  import bch_pkg::*;

  localparam int W   = 31;
  localparam int T   = 4;
  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_cw;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     syn_cw;
  logic [W*T-1:0]   syn_syn;
  logic             res_valid;
  logic             res_ready;
  logic [IDW-1:0]   res_id;
  logic [W*T-1:0]   res_syn;
  logic             res_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bch_syndrome_sched #(
    .C_INDWIDTH (W),
    .C_ERR_NUM  (T),
    .C_NUM_REQ  (N),
    .C_SYN_LAT  (LAT)
  ) dut (
    .I_clk           (clk),
    .I_rst_n         (rst_n),
    .I_req_valid     (req_valid),
    .I_req_codeword  (req_cw),
    .O_req_ready     (req_ready),
    .O_syn_codeword  (syn_cw),
    .I_syn_syndromes (syn_syn),
    .O_res_valid     (res_valid),
    .I_res_ready     (res_ready),
    .O_res_id        (res_id),
    .O_res_syndromes (res_syn),
    .O_res_err       (res_err)
  );

  // GF(2^31) with primitive polynomial x^31 + x^3 + 1; syndrome j is r(alpha^j).
  function automatic logic [W-1:0] mul_alpha(input logic [W-1:0] a);
    logic [W-1:0] s;
    s = a << 1;
    return a[W-1] ? (s ^ W'(9)) : s;
  endfunction

  function automatic logic [W*T-1:0] gf_syndromes(input logic [W-1:0] cw);
    logic [W*T-1:0] s;
    logic [W-1:0]   e;
    logic [W-1:0]   acc;
    s = '0;
    for (int j = 1; j <= T; j++) begin
      e   = W'(1);
      acc = '0;
      for (int i = 0; i < W; i++) begin
        if (cw[i]) acc = acc ^ e;
        for (int p = 0; p < j; p++) e = mul_alpha(e);
      end
      s[(j-1)*W +: W] = acc;
    end
    return s;
  endfunction

  // External registered syndrome unit, LAT stages deep.
  logic [W*T-1:0] syn_pipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) syn_pipe[k] <= '0;
    end else begin
      syn_pipe[0] <= gf_syndromes(syn_cw);
      for (int k = 1; k < LAT; k++) syn_pipe[k] <= syn_pipe[k-1];
    end
  end
  assign syn_syn = syn_pipe[LAT-1];

  // Scoreboard state
  int             m_ptr;
  bit             m_busy;
  int             m_since;
  bit             m_resv;
  int             m_id;
  logic [W*T-1:0] m_syn;
  logic [W-1:0]   m_cw;
  int             cycle_no = 0;
  int             accept_log[$];
  int             accept_cyc[$];

  task automatic checkOutput(input string tag, input logic [W*T-1:0] got, input logic [W*T-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    res_ready = rr;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    int r;
    for (int k = 1; k <= N; k++) begin
      r = (m_ptr + k) % N;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = N - 1;
    m_busy  = 0;
    m_since = 0;
    m_resv  = 0;
    m_id    = 0;
    m_syn   = '0;
    m_cw    = '0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic stepCycle();
    int           g;
    logic [N-1:0] exp_ready;
    bit           acc;
    bit           hs;
    @(negedge clk);
    g         = m_busy ? -1 : model_grant(req_valid);
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("syn_codeword", syn_cw, m_cw);
    checkOutput("res_valid", res_valid, m_resv);
    if (m_resv) begin
      checkOutput("res_id", res_id, m_id);
      checkOutput("res_syndromes", res_syn, m_syn);
      checkOutput("res_err", res_err, |m_syn);
    end
    acc = (g >= 0);
    hs  = m_resv && res_ready;
    @(posedge clk);
    cycle_no++;
    if (acc) begin
      m_busy  = 1;
      m_since = 0;
      m_ptr   = g;
      m_id    = g;
      m_cw    = req_cw[g*W +: W];
      m_syn   = gf_syndromes(m_cw);
      accept_log.push_back(g);
      accept_cyc.push_back(cycle_no);
    end else if (hs) begin
      m_resv = 0;
      m_busy = 0;
    end else if (m_busy && !m_resv) begin
      m_since++;
      if (m_since == LAT + 1) m_resv = 1;
    end
    #1;
  endtask

  task automatic drain();
    applyStimulus('0, 1'b1);
    for (int k = 0; k < 20 && m_busy; k++) stepCycle();
    checkOutput("drain_idle", {31'd0, m_busy}, '0);
  endtask

  task automatic randomize_codewords();
    for (int r = 0; r < N; r++) req_cw[r*W +: W] = W'($urandom);
  endtask

  initial begin
    int expected_order [6];
    expected_order = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    req_cw = '0;
    applyStimulus(4'hF, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", req_ready, '0);
    checkOutput("reset_res_valid", res_valid, '0);
    checkOutput("reset_syn_codeword", syn_cw, '0);
    rst_n = 1'b1;
    applyStimulus('0, 1'b0);

    // Requester 0, zero codeword: clean result two edges after accept.
    applyStimulus(4'b0001, 1'b0);
    stepCycle();
    checkOutput("t1_accept_id", accept_log[$], 0);
    applyStimulus('0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("t1_valid_after_2", res_valid, 1'b1);
    checkOutput("t1_err", res_err, 1'b0);
    drain();

    // Requester 1, single-bit error at bit 0: every syndrome equals 1.
    req_cw[1*W +: W] = W'(1);
    applyStimulus(4'b0010, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b0);
    stepCycle();
    stepCycle();
    for (int j = 0; j < T; j++) checkOutput($sformatf("t2_syn%0d", j), res_syn[j*W +: W], W'(1));
    checkOutput("t2_err", res_err, 1'b1);
    checkOutput("t2_id", res_id, 1);
    drain();

    // Hold in result state with downstream stalled for five cycles.
    randomize_codewords();
    applyStimulus(4'hF, 1'b0);
    for (int k = 0; k < 10 && !m_resv; k++) stepCycle();
    repeat (5) stepCycle();
    checkOutput("hold_valid", res_valid, 1'b1);
    applyStimulus(4'hF, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("hold_next_accept", accept_cyc[$], cycle_no);
    drain();

    // Pointer at 1; requester 2 drops while requester 3 arrives.
    applyStimulus(4'b0010, 1'b0);
    for (int k = 0; k < 10 && !(m_busy && m_id == 1); k++) stepCycle();
    applyStimulus(4'b0100, 1'b1);
    for (int k = 0; k < 20 && m_busy; k++) stepCycle();
    applyStimulus(4'b1000, 1'b1);
    stepCycle();
    checkOutput("ptr_req3_granted", accept_log[$], 3);
    drain();

    // Reset during WAIT clears outputs asynchronously; requester 0 wins afterwards.
    applyStimulus(4'b0001, 1'b0);
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, '0);
    checkOutput("rst_syn_codeword", syn_cw, '0);
    checkOutput("rst_res_valid", res_valid, '0);
    checkOutput("rst_res_id", res_id, '0);
    checkOutput("rst_res_syn", res_syn, '0);
    checkOutput("rst_res_err", res_err, '0);
    applyStimulus(4'hF, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_held_ready", req_ready, '0);
    model_reset();
    rst_n = 1'b1;
    accept_log.delete();
    accept_cyc.delete();
    for (int k = 0; k < 26; k++) begin
      randomize_codewords();
      stepCycle();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < accept_log.size()) begin
        checkOutput($sformatf("order%0d", k), accept_log[k], expected_order[k]);
        if (k > 0) checkOutput($sformatf("spacing%0d", k), accept_cyc[k] - accept_cyc[k-1], LAT + 3);
      end else begin
        checkOutput($sformatf("order%0d_missing", k), accept_log.size(), k + 1);
      end
    end
    drain();

    // Randomised traffic against the scoreboard.
    for (int k = 0; k < 1500; k++) begin
      randomize_codewords();
      if ($urandom_range(0, 7) == 0) req_cw[$urandom_range(0, N-1)*W +: W] = '0;
      applyStimulus(N'($urandom), $urandom_range(0, 3) != 0);
      stepCycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
